sw_input_conditioner: RTL and testbench



---
 rtl/sw_input_conditioner.sv | 83 ++++++++
 tb/tb_sw_input_conditioner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_input_conditioner.sv
// Switch input conditioner: per-bit synchronizer followed by an independent debounce counter.
// Emits a stable level, one-cycle rise/fall pulses, and sticky write-1-to-clear event flags.
module sw_input_conditioner #(
  parameter int unsigned NUM_SW      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_MAX     = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_SW-1:0] i_sw_raw,
  input  logic [NUM_SW-1:0] i_evt_clr,
  output logic [NUM_SW-1:0] o_io_sw,
  output logic [NUM_SW-1:0] o_rise,
  output logic [NUM_SW-1:0] o_fall,
  output logic [NUM_SW-1:0] o_evt,
  output logic              o_any_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [NUM_SW-1:0] sync_r [SYNC_STAGES];
  logic [NUM_SW-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_r   [NUM_SW];
  logic [CNT_W-1:0]  cnt_nxt [NUM_SW];
  logic [NUM_SW-1:0] commit;
  logic [NUM_SW-1:0] io_nxt;
  logic [NUM_SW-1:0] rise_nxt;
  logic [NUM_SW-1:0] fall_nxt;
  logic [NUM_SW-1:0] evt_nxt;

  assign sync_q = sync_r[SYNC_STAGES-1];

  // A bit commits on the cycle its mismatch run reaches CNT_MAX; any match restarts the run.
  always_comb begin
    commit = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q[i] != o_io_sw[i]) begin
        if (cnt_r[i] == CNT_LAST) begin
          commit[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_r[i] + 1'b1;
        end
      end
    end
    io_nxt   = o_io_sw ^ commit;
    rise_nxt = commit & sync_q;
    fall_nxt = commit & ~sync_q;
    // A fresh edge wins over a simultaneous clear so no event is dropped.
    evt_nxt  = rise_nxt | fall_nxt | (o_evt & ~i_evt_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= '0;
      end
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt_r[i] <= '0;
      end
      o_io_sw   <= '0;
      o_rise    <= '0;
      o_fall    <= '0;
      o_evt     <= '0;
      o_any_evt <= 1'b0;
    end else begin
      sync_r[0] <= i_sw_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt_r[i] <= cnt_nxt[i];
      end
      o_io_sw   <= io_nxt;
      o_rise    <= rise_nxt;
      o_fall    <= fall_nxt;
      o_evt     <= evt_nxt;
      o_any_evt <= |evt_nxt;
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Bench for sw_input_conditioner: scenario tasks with inline checks against a
// window-based reference model (commit when the last CNT_MAX synchronized samples all disagree).
module tb_sw_input_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned CMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sw_raw, evt_clr, io_sw, rise, fall, evt;
  logic        any_evt;

  logic       rst1;
  logic [7:0] raw1, clr1, io1, rise1, fall1, evt1;
  logic       any1;

  always #5 clk = ~clk;

  sw_input_conditioner #(.NUM_SW(32), .SYNC_STAGES(SYNC), .CNT_MAX(CMAX), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sw_raw(sw_raw), .i_evt_clr(evt_clr),
    .o_io_sw(io_sw), .o_rise(rise), .o_fall(fall), .o_evt(evt), .o_any_evt(any_evt)
  );

  sw_input_conditioner #(.NUM_SW(8), .SYNC_STAGES(3), .CNT_MAX(1), .CNT_W(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_sw_raw(raw1), .i_evt_clr(clr1),
    .o_io_sw(io1), .o_rise(rise1), .o_fall(fall1), .o_evt(evt1), .o_any_evt(any1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] pipe[$];
  logic [31:0] win[$];
  logic [31:0] m_io, m_rise, m_fall, m_evt;
  logic        m_any;

  task automatic model_edge(input logic [31:0] raw, input logic [31:0] clr, input logic r);
    logic [31:0] mism, commit;
    if (r) begin
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back('0);
      win.delete();
      m_io = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_any = 1'b0;
    end else begin
      win.push_back(pipe[SYNC-1]);
      if (win.size() > CMAX) void'(win.pop_front());
      mism = '1;
      foreach (win[j]) mism &= win[j] ^ m_io;
      commit = (win.size() == CMAX) ? mism : '0;
      m_io   = m_io ^ commit;
      m_rise = commit & m_io;
      m_fall = commit & ~m_io;
      m_evt  = (m_evt & ~clr) | m_rise | m_fall;
      m_any  = |m_evt;
      pipe.push_front(raw);
      void'(pipe.pop_back());
    end
  endtask

  task automatic step(input logic [31:0] raw, input logic [31:0] clr, input logic r);
    @(negedge clk);
    sw_raw = raw; evt_clr = clr; rst = r;
    @(posedge clk);
    model_edge(raw, clr, r);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step('1, '0, 1'b1);
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== '0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d io=%h rise=%h fall=%h evt=%h any=%b need all 0", c, io_sw, rise, fall, evt, any_evt);
      end
    end
    for (int c = 0; c < 7; c++) begin
      step('1, '0, 1'b0);
      n_vec++;
      if (io_sw !== ((c >= 5) ? 32'hFFFF_FFFF : 32'h0)) begin
        n_err++;
        $display("FAIL reset_latency c=%0d io=%h", c, io_sw);
      end
      n_vec++;
      if (rise !== ((c == 5) ? 32'hFFFF_FFFF : 32'h0) || any_evt !== (c >= 5)) begin
        n_err++;
        $display("FAIL reset_rise c=%0d rise=%h any=%b", c, rise, any_evt);
      end
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL reset_model c=%0d io=%h/%h evt=%h/%h", c, io_sw, m_io, evt, m_evt);
      end
    end
    // settle everything back to 0 and clear flags
    for (int c = 0; c < 8; c++) step('0, '1, 1'b0);
    n_vec++;
    if ({io_sw, evt, any_evt} !== '0) begin
      n_err++;
      $display("FAIL settle_zero io=%h evt=%h any=%b need 0", io_sw, evt, any_evt);
    end
  endtask

  task automatic test_clean_edge();
    for (int c = 0; c < 9; c++) begin
      step(32'h8, '0, 1'b0);
      n_vec++;
      if (io_sw[3] !== (c >= 5) || rise[3] !== (c == 5) || evt[3] !== (c >= 5)) begin
        n_err++;
        $display("FAIL clean_edge c=%0d io3=%b rise3=%b evt3=%b need %b %b %b",
                 c, io_sw[3], rise[3], evt[3], c >= 5, c == 5, c >= 5);
      end
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL clean_model c=%0d io=%h/%h rise=%h/%h", c, io_sw, m_io, rise, m_rise);
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 12; c++) begin
      step((c < 3) ? 32'h88 : 32'h8, '0, 1'b0);
      n_vec++;
      if (io_sw[7] !== 1'b0 || rise[7] !== 1'b0 || evt[7] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch c=%0d io7=%b rise7=%b evt7=%b need 0", c, io_sw[7], rise[7], evt[7]);
      end
    end
    n_vec++;
    if (u_dut.cnt_r[7] !== 16'd0) begin
      n_err++;
      $display("FAIL glitch_cnt cnt7=%0d need 0", u_dut.cnt_r[7]);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10101;
    int pulses = 0;
    int at = -1;
    for (int c = 0; c < 16; c++) begin
      step(32'h8 | ((c < 5) ? {31'b0, pat[c]} : 32'h1), '0, 1'b0);
      if (rise[0] === 1'b1) begin
        pulses++;
        at = c;
      end
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL bounce_model c=%0d io=%h/%h rise=%h/%h", c, io_sw, m_io, rise, m_rise);
      end
    end
    n_vec++;
    if (pulses !== 1 || at !== 9) begin
      n_err++;
      $display("FAIL bounce_pulse count=%0d at=%0d need 1 at 9", pulses, at);
    end
  endtask

  task automatic test_clear_vs_set();
    step(32'h9, '1, 1'b0);
    n_vec++;
    if (evt !== '0 || any_evt !== 1'b0) begin
      n_err++;
      $display("FAIL clr_all evt=%h any=%b need 0", evt, any_evt);
    end
    for (int c = 0; c < 7; c++) begin
      step(32'h1, (c >= 5) ? 32'h8 : 32'h0, 1'b0);
      n_vec++;
      if (c == 5 && (fall[3] !== 1'b1 || evt[3] !== 1'b1 || any_evt !== 1'b1)) begin
        n_err++;
        $display("FAIL set_beats_clr fall3=%b evt3=%b any=%b need 1 1 1", fall[3], evt[3], any_evt);
      end
      if (c == 6 && (evt !== '0 || any_evt !== 1'b0)) begin
        n_err++;
        $display("FAIL plain_clr evt=%h any=%b need 0 0", evt, any_evt);
      end
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL clr_model c=%0d evt=%h/%h fall=%h/%h", c, evt, m_evt, fall, m_fall);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) step(32'h21, '0, 1'b0);
    step(32'h21, '0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(32'h21, '0, 1'b0);
      n_vec++;
      if (io_sw[5] !== (c >= 5) || rise[5] !== (c == 5)) begin
        n_err++;
        $display("FAIL reset_mid c=%0d io5=%b rise5=%b need %b %b", c, io_sw[5], rise[5], c >= 5, c == 5);
      end
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL reset_mid_model c=%0d io=%h/%h", c, io_sw, m_io);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] raw = sw_raw;
    logic [31:0] clr;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 32; b++)
        if ($urandom_range(0, 6) == 0) raw[b] = ~raw[b];
      clr = $urandom() & $urandom();
      step(raw, clr, $urandom_range(0, 149) == 0);
      n_vec++;
      if ({io_sw, rise, fall, evt, any_evt} !== {m_io, m_rise, m_fall, m_evt, m_any}) begin
        n_err++;
        $display("FAIL random c=%0d io=%h/%h rise=%h/%h fall=%h/%h evt=%h/%h any=%b/%b",
                 c, io_sw, m_io, rise, m_rise, fall, m_fall, evt, m_evt, any_evt, m_any);
      end
    end
  endtask

  task automatic test_cnt_max1();
    logic [7:0] seq [10] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA4, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [7:0] e_io [10] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA4, 8'hA5};
    logic [7:0] e_rs [10] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic [7:0] e_fl [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    @(negedge clk); rst1 = 1'b1; raw1 = '0; clr1 = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); rst1 = 1'b0; raw1 = seq[c];
      @(posedge clk); #1;
      n_vec++;
      if (io1 !== e_io[c] || rise1 !== e_rs[c] || fall1 !== e_fl[c]) begin
        n_err++;
        $display("FAIL cnt_max1 c=%0d io=%h/%h rise=%h/%h fall=%h/%h",
                 c, io1, e_io[c], rise1, e_rs[c], fall1, e_fl[c]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sw_raw = '0; evt_clr = '0;
    rst1 = 1'b1; raw1 = '0; clr1 = '0;
    m_io = '0; m_rise = '0; m_fall = '0; m_evt = '0; m_any = 1'b0;
    for (int i = 0; i < SYNC; i++) pipe.push_back('0);
    test_reset();
    test_clean_edge();
    test_glitch();
    test_bounce();
    test_clear_vs_set();
    test_reset_mid();
    test_random();
    test_cnt_max1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
